// File: rtl/ifq_fetch_ctrl_if.sv
// Handshake bundle between the fetch sequencer, the I-cache port, the fetch queue
// and the branch redirect source. Signal directions are named from the sequencer's side.
interface ifq_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  i_redirect;
  logic [ADDR_WIDTH-1:0] i_redirect_addr;
  logic                  o_ic_req;
  logic [ADDR_WIDTH-1:0] o_ic_addr;
  logic                  i_ic_ready;
  logic                  i_ic_rvalid;
  logic [LINE_WIDTH-1:0] i_ic_rdata;
  logic                  i_fifo_full;
  logic                  o_fifo_wen;
  logic                  o_fifo_flush;
  logic [LINE_WIDTH-1:0] o_fifo_wdata;
  logic [1:0]            o_fifo_b32;
  logic                  o_redirect_busy;

  modport master (
    input  i_redirect, i_redirect_addr, i_ic_ready, i_ic_rvalid, i_ic_rdata, i_fifo_full,
    output o_ic_req, o_ic_addr, o_fifo_wen, o_fifo_flush, o_fifo_wdata, o_fifo_b32,
    output o_redirect_busy
  );

  modport slave (
    output i_redirect, i_redirect_addr, i_ic_ready, i_ic_rvalid, i_ic_rdata, i_fifo_full,
    input  o_ic_req, o_ic_addr, o_fifo_wen, o_fifo_flush, o_fifo_wdata, o_fifo_b32,
    input  o_redirect_busy
  );
endinterface

// File: rtl/ifq_fetch_ctrl.sv
// Fetch sequencer: one outstanding line request at a time, queue write/flush on return,
// redirects (and boot) become a flush carrying the target word offset; stale lines are dropped.
module ifq_fetch_ctrl #(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  LINE_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  ifq_fetch_ctrl_if.master  bus
);
  localparam int LW = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   line_pc_q, line_pc_d;
  logic            redir_pend_q, redir_pend_d;
  logic [1:0]      tgt_b32_q, tgt_b32_d;

  logic            ic_req, accept, wen, flush;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.i_redirect_addr[1:0];

  always_comb begin
    state_d      = state_q;
    line_pc_d    = line_pc_q;
    redir_pend_d = redir_pend_q;
    tgt_b32_d    = tgt_b32_q;
    wen          = 1'b0;
    flush        = 1'b0;
    ic_req       = (state_q == S_REQ) && (redir_pend_q || !bus.i_fifo_full);
    accept       = ic_req && bus.i_ic_ready;

    unique case (state_q)
      S_REQ: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_ic_rvalid) begin
          if (redir_pend_q) begin
            flush        = 1'b1;
            redir_pend_d = 1'b0;
          end else begin
            wen = 1'b1;
          end
          line_pc_d = line_pc_q + 1'b1;
          state_d   = S_REQ;
        end
      end
      S_DISCARD: begin
        if (bus.i_ic_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides the per-state result; the only thing kept is whether a
    // request is (still) in flight, which decides between S_REQ and S_DISCARD.
    if (bus.i_redirect) begin
      line_pc_d    = bus.i_redirect_addr[ADDR_WIDTH-1:4];
      tgt_b32_d    = bus.i_redirect_addr[3:2];
      redir_pend_d = 1'b1;
      wen          = 1'b0;
      flush        = 1'b0;
      unique case (state_q)
        S_REQ:   state_d = accept ? S_DISCARD : S_REQ;
        default: state_d = bus.i_ic_rvalid ? S_REQ : S_DISCARD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_REQ;
      line_pc_q    <= RESET_PC[ADDR_WIDTH-1:4];
      redir_pend_q <= 1'b1;
      tgt_b32_q    <= RESET_PC[3:2];
    end else begin
      state_q      <= state_d;
      line_pc_q    <= line_pc_d;
      redir_pend_q <= redir_pend_d;
      tgt_b32_q    <= tgt_b32_d;
    end
  end

  assign bus.o_ic_req        = ic_req && !i_rst;
  assign bus.o_ic_addr       = i_rst ? '0 : {line_pc_q, 4'b0000};
  assign bus.o_fifo_wen      = wen && !i_rst;
  assign bus.o_fifo_flush    = flush && !i_rst;
  assign bus.o_fifo_wdata    = i_rst ? '0 : bus.i_ic_rdata;
  assign bus.o_fifo_b32      = (flush && !i_rst) ? tgt_b32_q : 2'b00;
  assign bus.o_redirect_busy = redir_pend_q && !i_rst;
endmodule
